sprite_animator: RTL and testbench

Parametrised multi-frame sprite animator for the maze renderer. Holds a constant table of square bitmap frames, steps through them at a programmable rate of frame-rate ticks, and presents the current frame both as a full packed bitmap and as a registered single-pixel lookup for the VGA scan path. One instance per animated object: pellets, power pellets, Pac-Man mouth, ghost skirts.

---
 rtl/pacman_sprite_pkg.sv | 23 ++
 rtl/anim_frame_seq.sv | 98 +++++++++
 rtl/sprite_animator.sv | 67 ++++++
 tb/tb_sprite_animator.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pacman_sprite_pkg.sv
// Shared constants for the sprite animators: pellet frames, default frame table,
// sequencer direction type and an index-width helper.
package pacman_sprite_pkg;

  localparam int PELLET_SIZE = 5;

  localparam logic [24:0] PELLET_FRAME_0 = 25'b0000000110011100110000000;
  localparam logic [24:0] PELLET_FRAME_1 = 25'b0000001100011100011000000;

  // Frame k lives at bits [k*SIZE*SIZE +: SIZE*SIZE].
  localparam logic [49:0] PELLET_FRAMES = {PELLET_FRAME_1, PELLET_FRAME_0};

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } anim_dir_e;

  // Width of a counter/index over n values, never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/anim_frame_seq.sv
// Frame sequencer: tick divider, frame index, wrap pulse and (with
// ANIM_PINGPONG_EN defined) a direction register for bounce sequencing.
module anim_frame_seq
  import pacman_sprite_pkg::*;
#(
  parameter int NUM_FRAMES      = 2,
  parameter int TICKS_PER_FRAME = 1,
  parameter int FW              = idx_width(NUM_FRAMES)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick_en,
  input  logic          pause,
  input  logic          restart,
  output logic [FW-1:0] frame_idx,
  output logic [FW-1:0] frame_nxt,
  output logic          wrap
);

  localparam int DW = idx_width(TICKS_PER_FRAME);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICKS_PER_FRAME - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(NUM_FRAMES - 1);

  logic [DW-1:0] div;
  logic          accept;
  logic          step;
  logic          wrap_nxt;

  assign accept = tick_en & ~pause & ~restart;
  assign step   = accept && (div == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    div <= '0;
    else if (restart) div <= '0;
    else if (accept)  div <= step ? '0 : div + 1'b1;
  end

`ifdef ANIM_PINGPONG_EN
  anim_dir_e dir_q, dir_nxt;

  always_comb begin
    frame_nxt = frame_idx;
    dir_nxt   = dir_q;
    wrap_nxt  = 1'b0;
    if (restart) begin
      frame_nxt = '0;
      dir_nxt   = DIR_UP;
    end else if (step) begin
      if (NUM_FRAMES == 1) begin
        wrap_nxt = 1'b1;
      end else if (dir_q == DIR_UP) begin
        frame_nxt = frame_idx + 1'b1;
        if (frame_nxt == FRM_LAST) dir_nxt = DIR_DOWN;
      end else begin
        // Landing on frame 0 is the only wrap in bounce mode.
        frame_nxt = frame_idx - 1'b1;
        if (frame_nxt == '0) begin
          wrap_nxt = 1'b1;
          dir_nxt  = DIR_UP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dir_q <= DIR_UP;
    else          dir_q <= dir_nxt;
  end
`else
  always_comb begin
    frame_nxt = frame_idx;
    wrap_nxt  = 1'b0;
    if (restart) begin
      frame_nxt = '0;
    end else if (step) begin
      if (NUM_FRAMES == 1) begin
        wrap_nxt = 1'b1;
      end else if (frame_idx == FRM_LAST) begin
        frame_nxt = '0;
        wrap_nxt  = 1'b1;
      end else begin
        frame_nxt = frame_idx + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_idx <= '0;
      wrap      <= 1'b0;
    end else begin
      frame_idx <= frame_nxt;
      wrap      <= wrap_nxt;
    end
  end

endmodule

// File: rtl/sprite_animator.sv
// Multi-frame sprite animator: constant frame table, registered current bitmap and
// registered single-pixel lookup. Define ANIM_PINGPONG_EN for bounce sequencing.
module sprite_animator
  import pacman_sprite_pkg::*;
#(
  parameter int SIZE            = 5,
  parameter int NUM_FRAMES      = 2,
  parameter int TICKS_PER_FRAME = 1,
  parameter logic [NUM_FRAMES*SIZE*SIZE-1:0] FRAME_DATA = PELLET_FRAMES
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                tick_en,
  input  logic                                pause,
  input  logic                                restart,
  input  logic [$clog2(SIZE)-1:0]             pix_x,
  input  logic [$clog2(SIZE)-1:0]             pix_y,
  output logic [SIZE*SIZE-1:0]                shape,
  output logic [idx_width(NUM_FRAMES)-1:0]    frame_idx,
  output logic                                pix_out,
  output logic                                wrap
);

  localparam int SQ = SIZE * SIZE;
  localparam int FW = idx_width(NUM_FRAMES);
  localparam int PW = $clog2(SQ);

  logic [SQ-1:0] frames [NUM_FRAMES];
  logic [FW-1:0] frame_nxt;
  logic          in_range;
  logic [PW-1:0] pix_lin;

  for (genvar g = 0; g < NUM_FRAMES; g++) begin : g_frame
    assign frames[g] = FRAME_DATA[g*SQ +: SQ];
  end

  anim_frame_seq #(
    .NUM_FRAMES      (NUM_FRAMES),
    .TICKS_PER_FRAME (TICKS_PER_FRAME),
    .FW              (FW)
  ) u_seq (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick_en   (tick_en),
    .pause     (pause),
    .restart   (restart),
    .frame_idx (frame_idx),
    .frame_nxt (frame_nxt),
    .wrap      (wrap)
  );

  // Loaded from the sequencer's next index so shape and frame_idx change together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) shape <= FRAME_DATA[SQ-1:0];
    else          shape <= frames[frame_nxt];
  end

  assign in_range = (int'(pix_x) < SIZE) && (int'(pix_y) < SIZE);
  assign pix_lin  = PW'(int'(pix_y) * SIZE + int'(pix_x));

  // Reads shape as held before the edge, so a same-edge step returns the old frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pix_out <= 1'b0;
    else          pix_out <= in_range & shape[pix_lin];
  end

endmodule

// File: tb/tb_sprite_animator.sv
// Randomized + directed bench for sprite_animator: three instances (N2/T1, N4/T3,
// N4/T1) share stimulus and are compared every cycle against a step-count model.
module tb_sprite_animator;
  import pacman_sprite_pkg::*;

  localparam logic [24:0] F2 = 25'h1ABCDE5;
  localparam logic [24:0] F3 = 25'h0C3A5F1;
  localparam logic [99:0] FD4 = {F3, F2, PELLET_FRAME_1, PELLET_FRAME_0};

  logic clk = 1'b0;
  logic reset_n, tick_en, pause, restart;
  logic [2:0] pix_x, pix_y;
  logic [24:0] shape0, shape1, shape2;
  logic [0:0] fi0;
  logic [1:0] fi1, fi2;
  logic po0, po1, po2, wr0, wr1, wr2;

  always #5 clk = ~clk;

  sprite_animator u0 (
    .clk(clk), .reset_n(reset_n), .tick_en(tick_en), .pause(pause), .restart(restart),
    .pix_x(pix_x), .pix_y(pix_y), .shape(shape0), .frame_idx(fi0), .pix_out(po0), .wrap(wr0));

  sprite_animator #(.SIZE(5), .NUM_FRAMES(4), .TICKS_PER_FRAME(3), .FRAME_DATA(FD4)) u1 (
    .clk(clk), .reset_n(reset_n), .tick_en(tick_en), .pause(pause), .restart(restart),
    .pix_x(pix_x), .pix_y(pix_y), .shape(shape1), .frame_idx(fi1), .pix_out(po1), .wrap(wr1));

  sprite_animator #(.SIZE(5), .NUM_FRAMES(4), .TICKS_PER_FRAME(1), .FRAME_DATA(FD4)) u2 (
    .clk(clk), .reset_n(reset_n), .tick_en(tick_en), .pause(pause), .restart(restart),
    .pix_x(pix_x), .pix_y(pix_y), .shape(shape2), .frame_idx(fi2), .pix_out(po2), .wrap(wr2));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: per instance, frames advanced so far and ticks into the current period.
  int          nf [3] = '{2, 4, 4};
  int          tpf[3] = '{1, 3, 1};
  logic [24:0] tbl[4];
  int          m_steps[3], m_acc[3], m_frame[3];
  bit          m_wrap[3], m_pix[3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int seq_frame(input int n, input int s);
    int p;
    if (n == 1) return 0;
`ifdef ANIM_PINGPONG_EN
    p = s % (2 * (n - 1));
    return (p < n) ? p : 2 * (n - 1) - p;
`else
    p = s % n;
    return p;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_steps[k] = 0; m_acc[k] = 0; m_frame[k] = 0; m_wrap[k] = 0; m_pix[k] = 0;
    end
  endtask

  task automatic model_edge();
    int x, y;
    x = int'(pix_x);
    y = int'(pix_y);
    for (int k = 0; k < 3; k++) begin
      m_pix[k]  = (x < 5 && y < 5) ? tbl[m_frame[k]][y * 5 + x] : 1'b0;
      m_wrap[k] = 0;
      if (restart) begin
        m_steps[k] = 0; m_acc[k] = 0; m_frame[k] = 0;
      end else if (tick_en && !pause) begin
        m_acc[k]++;
        if (m_acc[k] == tpf[k]) begin
          m_acc[k]   = 0;
          m_steps[k]++;
          m_frame[k] = seq_frame(nf[k], m_steps[k]);
          m_wrap[k]  = (m_frame[k] == 0);
        end
      end
    end
  endtask

  task automatic check_all();
    chk("u0.frame", fi0, m_frame[0]);
    chk("u0.shape", shape0, tbl[m_frame[0]]);
    chk("u0.wrap", wr0, m_wrap[0]);
    chk("u0.pix", po0, m_pix[0]);
    chk("u1.frame", fi1, m_frame[1]);
    chk("u1.shape", shape1, tbl[m_frame[1]]);
    chk("u1.wrap", wr1, m_wrap[1]);
    chk("u1.pix", po1, m_pix[1]);
    chk("u2.frame", fi2, m_frame[2]);
    chk("u2.shape", shape2, tbl[m_frame[2]]);
    chk("u2.wrap", wr2, m_wrap[2]);
    chk("u2.pix", po2, m_pix[2]);
  endtask

  task automatic cyc(input bit t, input bit p, input bit r, input int x, input int y);
    tick_en = t; pause = p; restart = r;
    pix_x = 3'(x); pix_y = 3'(y);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    tbl[0] = PELLET_FRAME_0; tbl[1] = PELLET_FRAME_1; tbl[2] = F2; tbl[3] = F3;
    reset_n = 1'b0; tick_en = 0; pause = 0; restart = 0; pix_x = 0; pix_y = 0;
    model_reset();
    #12;
    check_all();
    chk("rst.shape", shape0, PELLET_FRAME_0);
    @(negedge clk);
    reset_n = 1'b1;

    // Tick trains with idle gaps: exercises wraps on all three instances.
    for (int i = 0; i < 13; i++) begin
      cyc(1, 0, 0, $urandom_range(0, 7), $urandom_range(0, 7));
      cyc(0, 0, 0, $urandom_range(0, 7), $urandom_range(0, 7));
    end

    // Pause holds a partial period.
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0);
    chk("pause.held", fi1, 0);
    cyc(1, 0, 0, 0, 0);
    chk("pause.step", fi1, 1);

    // Restart with a tick at frame 2, then restart while paused.
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1, 1);
    chk("pre.restart", fi1, 2);
    cyc(1, 0, 1, 1, 1);
    chk("restart.frame", fi1, 0);
    chk("restart.wrap", wr0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 1);
    cyc(1, 1, 1, 1, 1);
    chk("restart.pause", fi1, 0);

    // Pixel lookups at frame 0, out of range, and across a step edge.
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 2, 2);
    chk("pix.22", po0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("pix.00", po0, 0);
    cyc(0, 0, 0, 7, 1);
    chk("pix.oor", po0, 0);
    cyc(1, 0, 0, 3, 1);
    chk("pix.step.old", po0, 1);
    cyc(0, 0, 0, 3, 1);
    chk("pix.step.new", po0, 0);

    // Random traffic with an asynchronous reset mid-stream.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0),
          $urandom_range(0, 7), $urandom_range(0, 7));
      if (i == 700) begin
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        check_all();
        reset_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
